// File: rtl/hd_pkg.sv
// Shared types and constants for the hypervector bundling datapath.
// Counter width, memory geometry and saturation limits live here.
package hd_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int HV_DIM     = 1 << ADDR_WIDTH;

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH-1:0] CNT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        CLEAR  = 2'd1,
        THRESH = 2'd2,
        NOP    = 2'd3
    } hd_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_RD = 3'd1,
        ACC_WR = 3'd2,
        CLR_WR = 3'd3,
        TH_RD  = 3'd4,
        TH_CAP = 3'd5,
        OUT    = 3'd6
    } bundle_state_e;

endpackage

// File: rtl/hv_sat_inc.sv
// Signed +/-1 step that clamps at the counter limits.
// dir=1 counts up, dir=0 counts down.
module hv_sat_inc
    import hd_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  dir,
    output logic [DATA_WIDTH-1:0] result
);

    // hold at the limit instead of wrapping
    always_comb begin
        result = value;
        if (dir && (value != CNT_MAX)) begin
            result = value + DATA_WIDTH'(1);
        end else if (!dir && (value != CNT_MIN)) begin
            result = value - DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hv_bundle_ctrl.sv
// Read-modify-write controller bundling hypervectors into
// per-dimension counters, with clear and threshold commands.
module hv_bundle_ctrl
    import hd_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op,
    input  logic [HV_DIM-1:0]     op_hv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HV_DIM-1:0]     out_hv,
    output logic [15:0]           vec_count,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address_0,
    output logic [DATA_WIDTH-1:0] mem_data_0_in,
    output logic                  mem_we_0,
    output logic                  mem_oe_0,
    output logic [ADDR_WIDTH-1:0] mem_address_1,
    input  logic [DATA_WIDTH-1:0] mem_data_1_out,
    output logic                  mem_we_1,
    output logic                  mem_oe_1
);

    bundle_state_e         r_state;
    bundle_state_e         w_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [HV_DIM-1:0]     r_hv;
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [HV_DIM-1:0]     r_out_hv;
    logic [15:0]           r_vec_count;
    logic [DATA_WIDTH-1:0] w_sat;
    logic                  w_last;
    logic                  w_pos;

    assign w_last    = (r_idx == {ADDR_WIDTH{1'b1}});
    assign w_pos     = !r_rd_q[DATA_WIDTH-1] && (r_rd_q != '0);
    assign out_hv    = r_out_hv;
    assign vec_count = r_vec_count;
    assign busy      = (r_state != IDLE);
    assign mem_oe_0  = 1'b0;
    assign mem_we_1  = 1'b0;

    hv_sat_inc u_sat (
        .value  (r_rd_q),
        .dir    (r_hv[r_idx]),
        .result (w_sat)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and memory port decode from state and idx
    always_comb begin
        w_next        = r_state;
        op_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_address_0 = '0;
        mem_data_0_in = '0;
        mem_we_0      = 1'b0;
        mem_address_1 = '0;
        mem_oe_1      = 1'b0;
        unique case (r_state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (hd_op_e'(op))
                        ACCUM:   w_next = ACC_RD;
                        CLEAR:   w_next = CLR_WR;
                        THRESH:  w_next = TH_RD;
                        default: w_next = IDLE;
                    endcase
                end
            end
            ACC_RD: begin
                mem_address_1 = r_idx;
                mem_oe_1      = 1'b1;
                w_next        = ACC_WR;
            end
            ACC_WR: begin
                mem_address_0 = r_idx;
                mem_data_0_in = w_sat;
                mem_we_0      = 1'b1;
                w_next        = w_last ? IDLE : ACC_RD;
            end
            CLR_WR: begin
                mem_address_0 = r_idx;
                mem_we_0      = 1'b1;
                w_next        = w_last ? IDLE : CLR_WR;
            end
            TH_RD: begin
                mem_address_1 = r_idx;
                mem_oe_1      = 1'b1;
                w_next        = TH_CAP;
            end
            TH_CAP: begin
                w_next = w_last ? OUT : TH_RD;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // index, operand capture, read data, result and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_hv        <= '0;
            r_rd_q      <= '0;
            r_out_hv    <= '0;
            r_vec_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (op_valid && (hd_op_e'(op) == ACCUM)) begin
                        r_hv <= op_hv;
                    end
                end
                ACC_RD, TH_RD: begin
                    r_rd_q <= mem_data_1_out;
                end
                ACC_WR: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last && (r_vec_count != 16'hFFFF)) begin
                        r_vec_count <= r_vec_count + 16'd1;
                    end
                end
                CLR_WR: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_vec_count <= '0;
                end
                TH_CAP: begin
                    r_out_hv[r_idx] <= w_pos;
                    r_idx           <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
